// File: rtl/fir_coef_ctrl.sv
// Shadow/active FIR coefficient banks with frame-aligned, pipeline-drained bank swap.
// Stream path is 0-cycle combinational; ready passes through, gated closed during DRAIN and SWAP.
module fir_coef_ctrl #(
    parameter int TAP_NUM         = 15,
    parameter int FIR_TAP_WIDTH   = 16,
    parameter int SAXI_DATA_WIDTH = 16,
    parameter int FIR_LATENCY     = 23,
    parameter int ADDR_WIDTH      = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               cfg_wr_en_i,
    input  logic [ADDR_WIDTH-1:0]              cfg_wr_addr_i,
    input  logic [FIR_TAP_WIDTH-1:0]           cfg_wr_data_i,
    input  logic                               cfg_commit_i,
    output logic                               cfg_err_o,
    output logic                               commit_pending_o,
    output logic                               swap_done_o,
    output logic [1:0]                         state_o,
    input  logic [SAXI_DATA_WIDTH-1:0]         s_axis_tdata_i,
    input  logic                               s_axis_tvalid_i,
    input  logic                               s_axis_tlast_i,
    output logic                               s_axis_tready_o,
    output logic [SAXI_DATA_WIDTH-1:0]         m_axis_fir_tdata_o,
    output logic                               m_axis_fir_tvalid_o,
    output logic                               m_axis_fir_tlast_o,
    input  logic                               m_axis_fir_tready_i,
    output logic [TAP_NUM*FIR_TAP_WIDTH-1:0]   fir_taps_o
);

    localparam int CNT_W = $clog2(FIR_LATENCY + 1);
    localparam logic [CNT_W-1:0]         DRAIN_LOAD = CNT_W'(FIR_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0]      TAP_LIM    = TAP_NUM[ADDR_WIDTH:0];
    localparam logic [FIR_TAP_WIDTH-1:0] UNITY_TAP  = FIR_TAP_WIDTH'(16'h4000);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_EOF = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_SWAP     = 2'd3
    } state_t;

    state_t                   state;
    logic                     in_frame;
    logic                     pending;
    logic                     cfg_err;
    logic                     swap_done;
    logic [CNT_W-1:0]         drain_cnt;
    logic [FIR_TAP_WIDTH-1:0] shadow [TAP_NUM];
    logic [FIR_TAP_WIDTH-1:0] active [TAP_NUM];

    logic gate;
    logic beat_acc;
    logic in_frame_next;
    logic addr_ok;
    logic wr_ok;

    // Gate decodes straight from the state register so an async reset reopens it immediately.
    assign gate          = (state == ST_RUN) || (state == ST_WAIT_EOF);
    assign s_axis_tready_o     = m_axis_fir_tready_i & gate;
    assign m_axis_fir_tvalid_o = s_axis_tvalid_i & gate;
    assign m_axis_fir_tdata_o  = s_axis_tdata_i;
    assign m_axis_fir_tlast_o  = s_axis_tlast_i;

    assign beat_acc      = s_axis_tvalid_i & s_axis_tready_o;
    assign in_frame_next = beat_acc ? ~s_axis_tlast_i : in_frame;
    assign addr_ok       = ({1'b0, cfg_wr_addr_i} < TAP_LIM);
    assign wr_ok         = cfg_wr_en_i & addr_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_RUN;
            in_frame  <= 1'b0;
            pending   <= 1'b0;
            cfg_err   <= 1'b0;
            swap_done <= 1'b0;
            drain_cnt <= '0;
        end else begin
            in_frame  <= in_frame_next;
            cfg_err   <= cfg_wr_en_i & ~addr_ok;
            swap_done <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (cfg_commit_i) begin
                        pending <= 1'b1;
                        if (in_frame_next) begin
                            state <= ST_WAIT_EOF;
                        end else begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end
                end
                ST_WAIT_EOF: begin
                    if (beat_acc && s_axis_tlast_i) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_SWAP;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_SWAP: begin
                    pending   <= 1'b0;
                    swap_done <= 1'b1;
                    state     <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // A write landing in the SWAP cycle reaches shadow after active has sampled the old value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < TAP_NUM; n++) begin
                shadow[n] <= (n == TAP_NUM / 2) ? UNITY_TAP : '0;
                active[n] <= (n == TAP_NUM / 2) ? UNITY_TAP : '0;
            end
        end else begin
            if (wr_ok) begin
                shadow[cfg_wr_addr_i] <= cfg_wr_data_i;
            end
            if (state == ST_SWAP) begin
                for (int n = 0; n < TAP_NUM; n++) begin
                    active[n] <= shadow[n];
                end
            end
        end
    end

    for (genvar g = 0; g < TAP_NUM; g++) begin : g_taps
        assign fir_taps_o[g*FIR_TAP_WIDTH +: FIR_TAP_WIDTH] = active[g];
    end

    assign state_o          = state;
    assign commit_pending_o = pending;
    assign cfg_err_o        = cfg_err;
    assign swap_done_o      = swap_done;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Scoreboard bench for fir_coef_ctrl: stream beats, bank swaps and error pulses are
// queued by the stimulus and popped by an independent monitor.
module tb_fir_coef_ctrl;

    localparam int TN  = 15;
    localparam int W   = 16;
    localparam int LAT = 23;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_wr_en;
    logic [3:0]        cfg_wr_addr;
    logic [W-1:0]      cfg_wr_data;
    logic              cfg_commit;
    logic              cfg_err;
    logic              commit_pending;
    logic              swap_done;
    logic [1:0]        state;
    logic [W-1:0]      s_tdata;
    logic              s_tvalid;
    logic              s_tlast;
    logic              s_tready;
    logic [W-1:0]      m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [TN*W-1:0]   taps;

    fir_coef_ctrl dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .cfg_wr_en_i         (cfg_wr_en),
        .cfg_wr_addr_i       (cfg_wr_addr),
        .cfg_wr_data_i       (cfg_wr_data),
        .cfg_commit_i        (cfg_commit),
        .cfg_err_o           (cfg_err),
        .commit_pending_o    (commit_pending),
        .swap_done_o         (swap_done),
        .state_o             (state),
        .s_axis_tdata_i      (s_tdata),
        .s_axis_tvalid_i     (s_tvalid),
        .s_axis_tlast_i      (s_tlast),
        .s_axis_tready_o     (s_tready),
        .m_axis_fir_tdata_o  (m_tdata),
        .m_axis_fir_tvalid_o (m_tvalid),
        .m_axis_fir_tlast_o  (m_tlast),
        .m_axis_fir_tready_i (m_tready),
        .fir_taps_o          (taps)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_exp = 0;
    int err_seen = 0;

    logic [W:0]      beat_q [$];
    logic [TN*W-1:0] swap_q [$];

    logic [TN*W-1:0] b_reset, b1, b2, b2a;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a beat, a swap pulse or an error pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_beat", {239'd0, m_tlast, m_tdata}, 256'd0);
                    if ({m_tlast, m_tdata} == '0) check("unexpected_beat_zero", 256'd1, 256'd0);
                end else begin
                    check("beat", {239'd0, m_tlast, m_tdata}, {239'd0, beat_q.pop_front()});
                end
            end
            if (swap_done) begin
                if (swap_q.size() == 0) begin
                    check("unexpected_swap", 256'd1, 256'd0);
                end else begin
                    check("swap_taps", {16'd0, taps}, {16'd0, swap_q.pop_front()});
                    check("swap_pending_clr", {255'd0, commit_pending}, 256'd0);
                    check("swap_gate_open", {255'd0, s_tready}, {255'd0, m_tready});
                end
            end
            if (cfg_err) err_seen++;
        end
    end

    task automatic write_tap(input logic [3:0] a, input logic [W-1:0] d);
        cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic last);
        int n;
        n = 0;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
        do begin
            @(negedge clk);
            n++;
        end while (!s_tready && n < 50);
        if (!s_tready) check("beat_timeout", 256'd0, 256'd1);
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    // Commit from idle and count the cycles the gate stays shut; optionally re-commit mid-drain.
    task automatic commit_measure(input int commit_at, input string nm);
        int lows;
        lows = 0;
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        check({nm, "_pending"}, {255'd0, commit_pending}, 256'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cfg_commit = (i == commit_at);
            if (i == 0) check({nm, "_state_drain"}, {254'd0, state}, 256'd2);
            if (s_tready) break;
            lows++;
        end
        cfg_commit = 1'b0;
        check({nm, "_gate_cycles"}, 256'(lows), 256'(LAT + 1));
        @(posedge clk); #1;
    endtask

    task automatic wait_swap(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = swap_done;
        end
        if (!seen) check({nm, "_swap_timeout"}, 256'd0, 256'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        b_reset = '0;
        b_reset[7*W +: W] = 16'h4000;
        for (int n = 0; n < TN; n++) begin
            b1[n*W +: W] = W'(n + 1);
            b2[n*W +: W] = W'((n + 1) * 16'h0101);
        end
        b2a = b2;
        b2a[0 +: W] = 16'hAAAA;

        rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0; cfg_commit = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_taps", {16'd0, taps}, {16'd0, b_reset});
        check("rst_state", {254'd0, state}, 256'd0);
        check("rst_pending", {255'd0, commit_pending}, 256'd0);
        check("rst_ready_hi", {255'd0, s_tready}, 256'd1);
        m_tready = 1'b0; #1;
        check("rst_ready_lo", {255'd0, s_tready}, 256'd0);
        m_tready = 1'b1; #1;

        // Idle commit of bank 1
        for (int n = 0; n < TN; n++) write_tap(4'(n), W'(n + 1));
        swap_q.push_back(b1);
        commit_measure(-1, "idle");
        check("idle_taps_after", {16'd0, taps}, {16'd0, b1});

        // Commit inside a 10-beat frame
        for (int n = 0; n < TN; n++) write_tap(4'(n), W'((n + 1) * 16'h0101));
        swap_q.push_back(b2);
        for (int i = 0; i < 10; i++) begin
            beat_q.push_back({(i == 9) ? 1'b1 : 1'b0, W'(16'h0100 + i)});
            if (i == 3) cfg_commit = 1'b1;
            send_beat(W'(16'h0100 + i), i == 9);
            cfg_commit = 1'b0;
            if (i >= 3 && i < 9) check("frame_wait_eof", {254'd0, state}, 256'd1);
        end
        check("frame_state_drain", {254'd0, state}, 256'd2);
        check("frame_ready_dropped", {255'd0, s_tready}, 256'd0);
        check("frame_taps_old", {16'd0, taps}, {16'd0, b1});
        wait_swap("frame");

        // Commit coincident with the tlast beat goes straight to DRAIN
        swap_q.push_back(b2);
        beat_q.push_back({1'b0, 16'h0300});
        beat_q.push_back({1'b1, 16'h0301});
        send_beat(16'h0300, 1'b0);
        cfg_commit = 1'b1;
        send_beat(16'h0301, 1'b1);
        cfg_commit = 1'b0;
        check("tlast_commit_drain", {254'd0, state}, 256'd2);
        wait_swap("tlast");

        // Out-of-range write, then a duplicate commit during DRAIN
        write_tap(4'd15, 16'hFFFF);
        err_exp++;
        swap_q.push_back(b2);
        commit_measure(5, "dup");
        check("dup_taps", {16'd0, taps}, {16'd0, b2});

        // Write landing in the SWAP cycle
        swap_q.push_back(b2);
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        for (int i = 0; i < 60 && state != 2'd3; i++) begin
            @(posedge clk); #1;
        end
        check("reach_swap", {254'd0, state}, 256'd3);
        write_tap(4'd0, 16'hAAAA);
        check("swapwr_taps", {16'd0, taps}, {16'd0, b2});
        swap_q.push_back(b2a);
        commit_measure(-1, "swapwr2");
        check("swapwr2_taps", {16'd0, taps}, {16'd0, b2a});

        // Asynchronous reset in DRAIN
        write_tap(4'd3, 16'h1234);
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_drain", {254'd0, state}, 256'd2);
        rst = 1'b1; #1;
        check("arst_state", {254'd0, state}, 256'd0);
        check("arst_pending", {255'd0, commit_pending}, 256'd0);
        check("arst_ready", {255'd0, s_tready}, 256'd1);
        check("arst_taps", {16'd0, taps}, {16'd0, b_reset});
        @(posedge clk); #1;
        rst = 1'b0;
        swap_q.push_back(b_reset);
        commit_measure(-1, "post_rst");
        check("post_rst_taps", {16'd0, taps}, {16'd0, b_reset});

        repeat (30) @(posedge clk);
        #1;
        check("beat_q_empty", 256'(beat_q.size()), 256'd0);
        check("swap_q_empty", 256'(swap_q.size()), 256'd0);
        check("err_pulse_cycles", 256'(err_seen), 256'(err_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
